// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, op encodings,
// writable-field masks and the bit positions of the interrupt-enable fields.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // Masks are 64 bits wide; each user slices them down to its XLEN.
    localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_0088;
    localparam logic [63:0] MIE_WMASK     = 64'h0000_0000_0000_0888;
    localparam logic [63:0] MEPC_WMASK    = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] MTVEC_WMASK   = 64'hFFFF_FFFF_FFFF_FFFD;

    localparam int BIT_MIE  = 3;
    localparam int BIT_MPIE = 7;
    localparam int BIT_MSIE = 3;
    localparam int BIT_MTIE = 7;
    localparam int BIT_MEIE = 11;

    // RS/RC with rs1 = x0 only read the CSR.
    function automatic logic csr_op_writes(input logic [1:0] op, input logic wsup);
        return (op == CSR_OP_RW) || (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && !wsup);
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to the low half (or both) replaces the increment on that edge.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata_lo,
    input  logic [31:0] i_wdata_hi,
    output logic [63:0] o_value
);

    logic [63:0] r_count;
    logic [63:0] w_sum;

    assign w_sum   = r_count + 64'd1;
    assign o_value = r_count;

    // A high-half write keeps the low half counting; its carry is discarded
    // because the high half is being overwritten anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_wr_lo && i_wr_hi) begin
            r_count <= {i_wdata_hi, i_wdata_lo};
        end else if (i_wr_lo) begin
            r_count <= {r_count[63:32], i_wdata_lo};
        end else if (i_wr_hi) begin
            r_count <= {i_wdata_hi, (i_inc ? w_sum[31:0] : r_count[31:0])};
        end else if (i_inc) begin
            r_count <= w_sum;
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: software read-modify-write access, 64-bit counters,
// registered interrupt pending bits and atomic trap-entry / mret updates.
module csr_file
    import csr_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter int unsigned      HART_ID     = 0,
    parameter logic [XLEN-1:0]  MTVEC_RST   = '0,
    parameter bit               HAS_INSTRET = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csr_req_i,
    input  logic [1:0]       csr_op_i,
    input  logic [11:0]      csr_addr_i,
    input  logic [XLEN-1:0]  csr_wdata_i,
    input  logic             csr_wsup_i,
    output logic [XLEN-1:0]  csr_rdata_o,
    output logic             csr_illegal_o,
    input  logic             retire_i,
    input  logic             irq_ext_i,
    input  logic             irq_timer_i,
    input  logic             irq_soft_i,
    input  logic             trap_i,
    input  logic [XLEN-1:0]  trap_cause_i,
    input  logic [XLEN-1:0]  trap_pc_i,
    input  logic [XLEN-1:0]  trap_tval_i,
    input  logic             mret_i,
    output logic [XLEN-1:0]  trap_pc_o,
    output logic [XLEN-1:0]  mepc_o,
    output logic             irq_pending_o
);

    localparam logic [XLEN-1:0] L_MSTATUS_MASK = MSTATUS_WMASK[XLEN-1:0];
    localparam logic [XLEN-1:0] L_MIE_MASK     = MIE_WMASK[XLEN-1:0];
    localparam logic [XLEN-1:0] L_MEPC_MASK    = MEPC_WMASK[XLEN-1:0];
    localparam logic [XLEN-1:0] L_MTVEC_MASK   = MTVEC_WMASK[XLEN-1:0];

    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] r_mie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic [2:0]      r_irq;          // {ext, timer, soft}

    logic [XLEN-1:0] w_mip;
    logic [XLEN-1:0] w_misa;
    logic [XLEN-1:0] w_rdata;
    logic [XLEN-1:0] w_new;
    logic            w_valid;
    logic            w_ro;
    logic            w_is_write;
    logic            w_illegal;
    logic            w_wr_en;
    logic [XLEN-1:0] w_tvec_base;

    logic [63:0]     w_cycle;
    logic [63:0]     w_instret;
    logic [XLEN-1:0] w_cycle_lo;
    logic [XLEN-1:0] w_cycle_hi;
    logic [XLEN-1:0] w_instret_lo;
    logic [XLEN-1:0] w_instret_hi;
    logic [31:0]     w_cnt_wdata_lo;
    logic [31:0]     w_cnt_wdata_hi;
    logic            w_cyc_wr_lo;
    logic            w_cyc_wr_hi;
    logic            w_ret_wr_lo;
    logic            w_ret_wr_hi;

    always_comb begin
        w_mip           = '0;
        w_mip[BIT_MEIE] = r_irq[2];
        w_mip[BIT_MTIE] = r_irq[1];
        w_mip[BIT_MSIE] = r_irq[0];
    end

    always_comb begin
        w_misa                   = '0;
        w_misa[XLEN-1:XLEN-2]    = (XLEN == 64) ? 2'b10 : 2'b01;
        w_misa[8]                = 1'b1;
    end

    // Address decode: read value, implemented-ness and read-only attribute.
    always_comb begin
        w_rdata = '0;
        w_valid = 1'b0;
        w_ro    = 1'b0;
        case (csr_addr_i)
            CSR_MSTATUS:   begin w_valid = 1'b1; w_rdata = r_mstatus; end
            CSR_MISA:      begin w_valid = 1'b1; w_ro = 1'b1; w_rdata = w_misa; end
            CSR_MIE:       begin w_valid = 1'b1; w_rdata = r_mie; end
            CSR_MTVEC:     begin w_valid = 1'b1; w_rdata = r_mtvec & L_MTVEC_MASK; end
            CSR_MSCRATCH:  begin w_valid = 1'b1; w_rdata = r_mscratch; end
            CSR_MEPC:      begin w_valid = 1'b1; w_rdata = r_mepc; end
            CSR_MCAUSE:    begin w_valid = 1'b1; w_rdata = r_mcause; end
            CSR_MTVAL:     begin w_valid = 1'b1; w_rdata = r_mtval; end
            CSR_MIP:       begin w_valid = 1'b1; w_ro = 1'b1; w_rdata = w_mip; end
            CSR_MCYCLE:    begin w_valid = 1'b1; w_rdata = w_cycle_lo; end
            CSR_MINSTRET:  begin w_valid = 1'b1; w_rdata = w_instret_lo; end
            CSR_MCYCLEH:   begin w_valid = (XLEN == 32); w_rdata = w_cycle_hi; end
            CSR_MINSTRETH: begin w_valid = (XLEN == 32); w_rdata = w_instret_hi; end
            CSR_CYCLE:     begin w_valid = 1'b1; w_ro = 1'b1; w_rdata = w_cycle_lo; end
            CSR_INSTRET:   begin w_valid = 1'b1; w_ro = 1'b1; w_rdata = w_instret_lo; end
            CSR_CYCLEH:    begin w_valid = (XLEN == 32); w_ro = 1'b1; w_rdata = w_cycle_hi; end
            CSR_INSTRETH:  begin w_valid = (XLEN == 32); w_ro = 1'b1; w_rdata = w_instret_hi; end
            CSR_MHARTID:   begin w_valid = 1'b1; w_ro = 1'b1; w_rdata = XLEN'(HART_ID); end
            default:       begin w_valid = 1'b0; end
        endcase
    end

    always_comb begin
        case (csr_op_i)
            CSR_OP_RS: w_new = w_rdata | csr_wdata_i;
            CSR_OP_RC: w_new = w_rdata & ~csr_wdata_i;
            default:   w_new = csr_wdata_i;
        endcase
    end

    assign w_is_write = csr_req_i && csr_op_writes(csr_op_i, csr_wsup_i);
    assign w_illegal  = csr_req_i && (!w_valid || (w_ro && w_is_write));
    // The instruction is squashed when a trap or mret lands in the same cycle.
    assign w_wr_en    = w_is_write && !w_illegal && !trap_i && !mret_i;

    assign csr_rdata_o   = w_rdata;
    assign csr_illegal_o = w_illegal;
    assign mepc_o        = r_mepc;
    assign irq_pending_o = r_mstatus[BIT_MIE] && (|(w_mip & r_mie));

    assign w_tvec_base = {r_mtvec[XLEN-1:2], 2'b00};
    assign trap_pc_o   = (r_mtvec[0] && trap_cause_i[XLEN-1])
                       ? w_tvec_base + XLEN'({trap_cause_i[XLEN-2:0], 2'b00})
                       : w_tvec_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstatus  <= '0;
            r_mie      <= '0;
            r_mtvec    <= MTVEC_RST;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
            r_irq      <= '0;
        end else begin
            r_irq <= {irq_ext_i, irq_timer_i, irq_soft_i};
            if (trap_i) begin
                r_mepc               <= trap_pc_i & L_MEPC_MASK;
                r_mcause             <= trap_cause_i;
                r_mtval              <= trap_tval_i;
                r_mstatus[BIT_MPIE]  <= r_mstatus[BIT_MIE];
                r_mstatus[BIT_MIE]   <= 1'b0;
            end else if (mret_i) begin
                r_mstatus[BIT_MIE]   <= r_mstatus[BIT_MPIE];
                r_mstatus[BIT_MPIE]  <= 1'b1;
            end else if (w_wr_en) begin
                case (csr_addr_i)
                    CSR_MSTATUS:  r_mstatus  <= w_new & L_MSTATUS_MASK;
                    CSR_MIE:      r_mie      <= w_new & L_MIE_MASK;
                    CSR_MTVEC:    r_mtvec    <= w_new & L_MTVEC_MASK;
                    CSR_MSCRATCH: r_mscratch <= w_new & L_MEPC_MASK;
                    CSR_MEPC:     r_mepc     <= w_new & L_MEPC_MASK;
                    CSR_MCAUSE:   r_mcause   <= w_new;
                    CSR_MTVAL:    r_mtval    <= w_new;
                    default:      ;
                endcase
            end
        end
    end

    assign w_cyc_wr_lo = w_wr_en && (csr_addr_i == CSR_MCYCLE);
    assign w_ret_wr_lo = w_wr_en && (csr_addr_i == CSR_MINSTRET);

    // At XLEN=64 a single write covers both halves; at 32 the *h CSRs do.
    generate
        if (XLEN == 64) begin : g_x64
            assign w_cnt_wdata_lo = w_new[31:0];
            assign w_cnt_wdata_hi = w_new[63:32];
            assign w_cyc_wr_hi    = w_cyc_wr_lo;
            assign w_ret_wr_hi    = w_ret_wr_lo;
            assign w_cycle_lo     = w_cycle;
            assign w_cycle_hi     = '0;
            assign w_instret_lo   = w_instret;
            assign w_instret_hi   = '0;
        end else begin : g_x32
            assign w_cnt_wdata_lo = w_new;
            assign w_cnt_wdata_hi = w_new;
            assign w_cyc_wr_hi    = w_wr_en && (csr_addr_i == CSR_MCYCLEH);
            assign w_ret_wr_hi    = w_wr_en && (csr_addr_i == CSR_MINSTRETH);
            assign w_cycle_lo     = w_cycle[31:0];
            assign w_cycle_hi     = w_cycle[63:32];
            assign w_instret_lo   = w_instret[31:0];
            assign w_instret_hi   = w_instret[63:32];
        end
    endgenerate

    csr_counter64 u_mcycle (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (1'b1),
        .i_wr_lo    (w_cyc_wr_lo),
        .i_wr_hi    (w_cyc_wr_hi),
        .i_wdata_lo (w_cnt_wdata_lo),
        .i_wdata_hi (w_cnt_wdata_hi),
        .o_value    (w_cycle)
    );

    generate
        if (HAS_INSTRET) begin : g_instret
            csr_counter64 u_minstret (
                .clk        (clk),
                .rst        (rst),
                .i_inc      (retire_i),
                .i_wr_lo    (w_ret_wr_lo),
                .i_wr_hi    (w_ret_wr_hi),
                .i_wdata_lo (w_cnt_wdata_lo),
                .i_wdata_hi (w_cnt_wdata_hi),
                .o_value    (w_instret)
            );
        end else begin : g_no_instret
            assign w_instret = '0;
        end
    endgenerate

endmodule
